// File: rtl/burst_generator_if.sv
// Request/burst bus between a request source, the burst generator and the
// burst consumer. The generator is the master: it drives start/data.
interface burst_if #(
  parameter int DATA_W = 4
);
  logic              req;
  logic [DATA_W-1:0] req_seed;
  logic              req_ready;
  logic              start;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              done;
  logic              busy;
  logic [7:0]        burst_cnt;

  modport master (
    input  req, req_seed,
    output req_ready, start, data, data_valid, done, busy, burst_cnt
  );

  modport slave (
    output req, req_seed,
    input  req_ready, start, data, data_valid, done, busy, burst_cnt
  );
endinterface

// File: rtl/burst_generator.sv
// Burst generator: one-cycle start strobe followed by BURST_LEN non-zero
// beats, with a one-deep holding register for a request that arrives while
// a burst is in flight. All outputs come straight from flops.
module burst_generator #(
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 4,
  parameter int MIN_GAP   = 1
) (
  input  logic   clk,
  input  logic   rst,
  burst_if.master bus
);
  typedef enum logic [1:0] {IDLE, START, BURST, GAP} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [4:0] LAST_GAP  = (MIN_GAP > 0) ? 5'(MIN_GAP - 1) : 5'd0;

  state_t            state, state_n;
  logic [4:0]        cnt, cnt_n;
  logic [DATA_W-1:0] seed_q, seed_n;
  logic              hold_vld, hold_vld_n;
  logic [DATA_W-1:0] hold_seed, hold_seed_n;
  logic              start_q, dv_q, done_q, busy_q, rdy_q;
  logic [DATA_W-1:0] data_q, data_n;
  logic [7:0]        bcnt_q, bcnt_n;
  logic              accept, avail, launch;

  // Next value in the beat sequence: wraps past all-ones to 1, never 0.
  function automatic logic [DATA_W-1:0] succ(input logic [DATA_W-1:0] v);
    return (&v) ? DATA_W'(1) : v + DATA_W'(1);
  endfunction

  // A zero seed would put a zero beat on the bus, so it is promoted to 1.
  function automatic logic [DATA_W-1:0] fix_seed(input logic [DATA_W-1:0] v);
    return (v == '0) ? DATA_W'(1) : v;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, beat sequencing and holding-register bookkeeping.
  // Every point where a new burst may begin (IDLE, end of GAP, end of BURST
  // with no gap) uses the same launch rule, so a queued request starts after
  // exactly MIN_GAP idle cycles instead of paying an extra IDLE cycle.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    seed_n      = seed_q;
    data_n      = '0;
    hold_vld_n  = hold_vld;
    hold_seed_n = hold_seed;
    bcnt_n      = bcnt_q;
    launch      = 1'b0;
    accept      = bus.req && rdy_q;
    avail       = hold_vld || accept;
    unique case (state)
      IDLE:  launch = avail;
      START: begin
        state_n = BURST;
        cnt_n   = '0;
        data_n  = seed_q;
      end
      BURST: begin
        if (cnt == LAST_BEAT) begin
          bcnt_n = bcnt_q + 8'd1;
          if (MIN_GAP > 0) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            launch  = avail;
          end
        end else begin
          cnt_n  = cnt + 5'd1;
          data_n = succ(data_q);
        end
      end
      GAP: begin
        if (cnt == LAST_GAP) begin
          state_n = IDLE;
          launch  = avail;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // The holding register has priority over a request arriving this edge.
    if (launch) begin
      state_n = START;
      seed_n  = fix_seed(hold_vld ? hold_seed : bus.req_seed);
      if (hold_vld) hold_vld_n = 1'b0;
    end
    // Park any accepted request that is not launched directly on this edge.
    if (accept && !(launch && !hold_vld)) begin
      hold_vld_n  = 1'b1;
      hold_seed_n = bus.req_seed;
    end
  end

  // Datapath and registered outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      seed_q    <= '0;
      hold_vld  <= 1'b0;
      hold_seed <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b1;
      bcnt_q    <= '0;
    end else begin
      cnt       <= cnt_n;
      seed_q    <= seed_n;
      hold_vld  <= hold_vld_n;
      hold_seed <= hold_seed_n;
      start_q   <= (state_n == START);
      data_q    <= data_n;
      dv_q      <= (state_n == BURST);
      done_q    <= (state_n == BURST) && (cnt_n == LAST_BEAT);
      busy_q    <= (state_n != IDLE);
      rdy_q     <= !hold_vld_n;
      bcnt_q    <= bcnt_n;
    end
  end

  assign bus.req_ready  = rdy_q;
  assign bus.start      = start_q;
  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.burst_cnt  = bcnt_q;
endmodule
